// File: rtl/two_of_five_pkg.sv
// Shared definitions for the 2-of-5 serializer and the downstream checker.
//   code_t        : 5-bit POSTNET code word, weights 7-4-2-1-0, code[0] sent first
//   CODE_LEN      : bits per frame
//   BAD_CODE      : word sent for a digit outside 0..9
//   encode_digit  : decimal digit -> code word
package two_of_five_pkg;

  typedef logic [4:0] code_t;

  localparam int unsigned CODE_LEN = 5;
  localparam int unsigned DIGIT_W  = 4;
  localparam code_t       BAD_CODE = 5'b00000;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } shift_state_e;

  function automatic code_t encode_digit(logic [3:0] d);
    code_t c;
    case (d)
      4'd0:    c = 5'b11000;
      4'd1:    c = 5'b00011;
      4'd2:    c = 5'b00101;
      4'd3:    c = 5'b00110;
      4'd4:    c = 5'b01001;
      4'd5:    c = 5'b01010;
      4'd6:    c = 5'b01100;
      4'd7:    c = 5'b10001;
      4'd8:    c = 5'b10010;
      4'd9:    c = 5'b10100;
      default: c = BAD_CODE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/two_of_five_serializer_if.sv
// Digit handshake between a digit source and the serializer.
//   digit        : decimal digit (0..9 legal, 10..15 flagged as error)
//   digit_valid  : source presents a digit
//   digit_ready  : serializer FIFO can accept
// Modports: master = digit source, slave = serializer.
interface two_of_five_serializer_if;
  import two_of_five_pkg::*;

  logic [DIGIT_W-1:0] digit;
  logic               digit_valid;
  logic               digit_ready;

  modport master (
    output digit,
    output digit_valid,
    input  digit_ready
  );

  modport slave (
    input  digit,
    input  digit_valid,
    output digit_ready
  );

endinterface

// File: rtl/two_of_five_fifo.sv
// Synchronous FIFO with a separate occupancy count.
//   i_clk, i_rstn : clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_din : write strobe and data; caller must not push when full
//   i_pop         : read strobe; caller must not pop when empty
//   o_head        : oldest entry (valid when !o_empty)
//   o_full/o_empty: occupancy flags, pure register state
module two_of_five_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW:0]    r_count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/two_of_five_serializer.sv
// Accepts decimal digits, queues them, encodes each to a 2-of-5 word and shifts it out
// code[0] first, one bit per clock, frames back-to-back with no gap.
//   i_clk, i_rstn : clock, synchronous active-low reset (truncates any frame in flight)
//   io_dig        : digit handshake (slave side); digit_ready = !fifo_full
//   o_out         : serial code bit (IDLE_LEVEL between frames)
//   o_active      : o_out carries a code bit
//   o_frame_start : o_out carries bit 0 of a frame
//   o_err         : one-cycle pulse after accepting a digit > 9
module two_of_five_serializer
  import two_of_five_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  two_of_five_serializer_if.slave        io_dig,
  output logic                           o_out,
  output logic                           o_active,
  output logic                           o_frame_start,
  output logic                           o_err
);

  localparam logic [2:0] LastBit = 3'(CODE_LEN - 1);

  logic [DIGIT_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_load;
  code_t              w_code;

  shift_state_e r_state,  w_state_d;
  code_t        r_shift,  w_shift_d;
  logic [2:0]   r_bitcnt, w_bitcnt_d;
  logic         r_out,    w_out_d;
  logic         r_fs,     w_fs_d;
  logic         r_err,    w_err_d;

  // Ready is pure FIFO state: no look-ahead on a same-cycle pop.
  assign io_dig.digit_ready = !w_full;
  assign w_push = io_dig.digit_valid && !w_full;

  // Load when the shifter is idle or emitting its final bit, giving gapless frames.
  assign w_load = !w_empty && ((r_state == StIdle) || (r_bitcnt == LastBit));
  assign w_code = encode_digit(w_head);

  two_of_five_fifo #(
    .WIDTH(DIGIT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_push (w_push),
    .i_din  (io_dig.digit),
    .i_pop  (w_load),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_bitcnt_d = r_bitcnt;
    w_out_d    = IDLE_LEVEL;
    w_fs_d     = 1'b0;
    w_err_d    = w_push && (io_dig.digit > 4'd9);

    if (w_load) begin
      w_state_d  = StShift;
      w_shift_d  = w_code;
      w_bitcnt_d = '0;
      w_out_d    = w_code[0];
      w_fs_d     = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_bitcnt_d = '0;
        end
        StShift: begin
          if (r_bitcnt == LastBit) begin
            w_state_d  = StIdle;
            w_shift_d  = '0;
            w_bitcnt_d = '0;
          end else begin
            // r_shift[0] is on the line now; the next bit is r_shift[1].
            w_shift_d  = r_shift >> 1;
            w_bitcnt_d = r_bitcnt + 3'd1;
            w_out_d    = r_shift[1];
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_out    <= IDLE_LEVEL;
      r_fs     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_bitcnt <= w_bitcnt_d;
      r_out    <= w_out_d;
      r_fs     <= w_fs_d;
      r_err    <= w_err_d;
    end
  end

  assign o_out         = r_out;
  assign o_active      = (r_state == StShift);
  assign o_frame_start = r_fs;
  assign o_err         = r_err;

endmodule

// File: tb/tb_two_of_five_serializer.sv
// Directed bench for two_of_five_serializer (DEPTH=2, IDLE_LEVEL=0).
module tb_two_of_five_serializer;
  import two_of_five_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic out, active, frame_start, err;

  always #5 clk = ~clk;

  two_of_five_serializer_if dig ();

  two_of_five_serializer #(
    .DEPTH     (2),
    .IDLE_LEVEL(1'b0)
  ) u_dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .io_dig       (dig),
    .o_out        (out),
    .o_active     (active),
    .o_frame_start(frame_start),
    .o_err        (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-written code table, index = digit.
  logic [4:0] c_tab [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                             5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

  // Frame collector: records completed 5-bit frames and lengths of active runs.
  logic [4:0] frames [$];
  int         runs [$];
  int         err_pulses = 0;
  int         fs_bad     = 0;
  logic [4:0] cur;
  int         cur_n = 0;
  int         run   = 0;

  always @(posedge clk) begin
    #1;
    if (err === 1'b1) err_pulses++;
    if (active === 1'b1) begin
      if (frame_start !== (cur_n == 0)) fs_bad++;
      if (frame_start === 1'b1) cur_n = 0;
      cur[cur_n] = out;
      cur_n++;
      run++;
      if (cur_n == 5) begin
        frames.push_back(cur);
        cur_n = 0;
      end
    end else begin
      if (frame_start === 1'b1) fs_bad++;
      if (run > 0) runs.push_back(run);
      run   = 0;
      cur_n = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_digit(input string tag, input logic [3:0] d);
    int k;
    k = 0;
    while (dig.digit_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check($sformatf("%s_ready", tag), dig.digit_ready, 1);
    dig.digit       = d;
    dig.digit_valid = 1'b1;
    tick();
    dig.digit_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [4:0] code);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("%s_out_b%0d", tag, k), out, code[k]);
      check($sformatf("%s_act_b%0d", tag, k), active, 1);
      check($sformatf("%s_fs_b%0d", tag, k), frame_start, (k == 0));
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (active !== 1'b0 && k < 200) begin
      tick();
      k++;
    end
    check($sformatf("%s_idle", tag), active, 0);
    tick();
    tick();
  endtask

  int fb, eb;

  initial begin
    // T1: reset held with valid asserted
    rstn            = 1'b0;
    dig.digit       = 4'd5;
    dig.digit_valid = 1'b1;
    repeat (3) tick();
    check("t1_out", out, 0);
    check("t1_active", active, 0);
    check("t1_fs", frame_start, 0);
    check("t1_err", err, 0);
    check("t1_ready", dig.digit_ready, 1);
    dig.digit_valid = 1'b0;
    rstn            = 1'b1;
    tick();
    check("t1_ready_post", dig.digit_ready, 1);
    check("t1_active_post", active, 0);
    tick();
    check("t1_active_post2", active, 0);

    // T2: single digit 5 -> 0,1,0,1,0
    push_digit("t2", 4'd5);
    check("t2_lat_active", active, 0);
    check("t2_err", err, 0);
    expect_frame("t2", 5'b01010);
    tick();
    check("t2_end_active", active, 0);
    check("t2_end_out", out, 0);
    check("t2_end_fs", frame_start, 0);

    // T3: stream 1..9,0, gapless
    fb = frames.size();
    for (int i = 1; i <= 10; i++) push_digit($sformatf("t3_%0d", i), 4'(i % 10));
    wait_idle("t3");
    check("t3_nframes", frames.size() - fb, 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("t3_frame%0d", i), frames[fb+i], c_tab[(i+1)%10]);
    check("t3_run50", runs[runs.size()-1], 50);
    check("t3_fs_spacing", fs_bad, 0);

    // T4: 7, 12, 7
    fb = frames.size();
    eb = err_pulses;
    push_digit("t4_a", 4'd7);
    check("t4_err_lo_a", err, 0);
    push_digit("t4_b", 4'd12);
    check("t4_err_hi", err, 1);
    push_digit("t4_c", 4'd7);
    check("t4_err_lo_c", err, 0);
    wait_idle("t4");
    check("t4_err_pulses", err_pulses - eb, 1);
    check("t4_nframes", frames.size() - fb, 3);
    check("t4_frame0", frames[fb], 5'b10001);
    check("t4_frame1", frames[fb+1], 5'b00000);
    check("t4_frame2", frames[fb+2], 5'b10001);

    // T5: backpressure with DEPTH=2, valid held high
    fb = frames.size();
    dig.digit_valid = 1'b1;
    dig.digit       = 4'd2;
    tick();                                   // e1: push 2
    check("t5_ready_e1", dig.digit_ready, 1);
    dig.digit = 4'd4;
    tick();                                   // e2: push 4, pop 2
    check("t5_ready_e2", dig.digit_ready, 1);
    dig.digit = 4'd6;
    tick();                                   // e3: push 6, FIFO full
    check("t5_ready_e3", dig.digit_ready, 0);
    dig.digit = 4'd8;
    tick();
    check("t5_ready_e4", dig.digit_ready, 0);
    tick();
    check("t5_ready_e5", dig.digit_ready, 0);
    tick();
    check("t5_ready_e6", dig.digit_ready, 0);
    tick();                                   // e7: pop 4
    check("t5_ready_e7", dig.digit_ready, 1);
    tick();                                   // e8: push 8
    dig.digit_valid = 1'b0;
    check("t5_ready_e8", dig.digit_ready, 0);
    wait_idle("t5");
    check("t5_nframes", frames.size() - fb, 4);
    check("t5_frame0", frames[fb], 5'b00101);
    check("t5_frame1", frames[fb+1], 5'b01001);
    check("t5_frame2", frames[fb+2], 5'b01100);
    check("t5_frame3", frames[fb+3], 5'b10010);

    // T6: reset during bit 2 of digit 8 with two digits queued
    dig.digit_valid = 1'b1;
    dig.digit       = 4'd8;
    tick();                                   // e1: push 8
    dig.digit = 4'd1;
    tick();                                   // e2: load 8, push 1
    check("t6_b0", out, 0);
    dig.digit = 4'd2;
    tick();                                   // e3: push 2
    dig.digit_valid = 1'b0;
    check("t6_b1", out, 1);
    check("t6_ready_full", dig.digit_ready, 0);
    tick();                                   // e4: bit 2
    check("t6_b2_out", out, 0);
    check("t6_b2_act", active, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t6_rst_out", out, 0);
    check("t6_rst_act", active, 0);
    check("t6_rst_ready", dig.digit_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_quiet%0d", i), active, 0);
    end
    push_digit("t6", 4'd3);
    expect_frame("t6", 5'b00110);
    tick();
    check("t6_end_active", active, 0);
    check("t6_end_out", out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
